// File: rtl/stopwatch_pkg.sv
// Shared constants for the tenths-of-a-second stopwatch.
// Holds FSM state encoding, digit width and the seconds-tens limit.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] LAP   = 2'd2;
  localparam logic [1:0] PAUSE = 2'd3;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One wrapping BCD digit of the cascaded stopwatch counter.
// Ports: clock_in, reset, clr, inc in; q (digit), carry (wrap on inc) out.
import stopwatch_pkg::*;

module bcd_digit #(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic [DIGIT_W-1:0] r_q;
  logic               w_at_max;

  assign w_at_max = (r_q == MAX);
  assign carry    = inc & w_at_max;
  assign q        = r_q;

  always_ff @(posedge clock_in) begin
    if (reset || clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= w_at_max ? '0 : r_q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: edge detect, RUN/LAP/PAUSE FSM, lap freeze, BCD display.
// Ports: clock_in, reset, tick_in, btn_* in; digit0..3, running,
// lap_active, rollover out.
import stopwatch_pkg::*;

module stopwatch_core #(
  parameter int TENTHS_MAX = 9,
  parameter int MIN_MAX    = 9
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               btn_start,
  input  logic               btn_lap,
  input  logic               btn_clear,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit3,
  output logic               running,
  output logic               lap_active,
  output logic               rollover
);

  logic                    r_tick_q;
  logic                    r_start_q;
  logic                    r_lap_q;
  logic                    r_clear_q;
  logic [1:0]              r_state;
  logic [3:0][DIGIT_W-1:0] r_lap;
  logic                    r_roll;

  logic                    w_tick_ev;
  logic                    w_start_ev;
  logic                    w_lap_ev;
  logic                    w_clear_ev;
  logic                    w_counting;
  logic                    w_inc;
  logic                    w_clear;
  logic [1:0]              w_state_nx;
  logic                    w_lap_load;
  logic [3:0]              w_carry;
  logic [3:0][DIGIT_W-1:0] w_live;
  logic [3:0][DIGIT_W-1:0] w_disp;

  assign w_tick_ev  = tick_in ^ r_tick_q;
  assign w_start_ev = btn_start & ~r_start_q;
  assign w_lap_ev   = btn_lap & ~r_lap_q;
  assign w_clear_ev = btn_clear & ~r_clear_q;

  assign w_counting = (r_state == RUN) | (r_state == LAP);
  assign w_inc      = w_tick_ev & w_counting;

  // A lap press outranks clear even in PAUSE, where lap itself is a no-op.
  assign w_clear = (r_state == PAUSE) & w_clear_ev
                 & ~w_start_ev & ~w_lap_ev;

  bcd_digit #(.MAX(DIGIT_W'(TENTHS_MAX))) u_d0 (
    .clock_in (clock_in),
    .reset    (reset),
    .clr      (w_clear),
    .inc      (w_inc),
    .q        (w_live[0]),
    .carry    (w_carry[0])
  );

  bcd_digit #(.MAX(4'd9)) u_d1 (
    .clock_in (clock_in),
    .reset    (reset),
    .clr      (w_clear),
    .inc      (w_carry[0]),
    .q        (w_live[1]),
    .carry    (w_carry[1])
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_d2 (
    .clock_in (clock_in),
    .reset    (reset),
    .clr      (w_clear),
    .inc      (w_carry[1]),
    .q        (w_live[2]),
    .carry    (w_carry[2])
  );

  bcd_digit #(.MAX(DIGIT_W'(MIN_MAX))) u_d3 (
    .clock_in (clock_in),
    .reset    (reset),
    .clr      (w_clear),
    .inc      (w_carry[2]),
    .q        (w_live[3]),
    .carry    (w_carry[3])
  );

  always_comb begin
    w_state_nx = r_state;
    w_lap_load = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start_ev) w_state_nx = RUN;
      end
      RUN: begin
        if (w_start_ev) begin
          w_state_nx = PAUSE;
        end else if (w_lap_ev) begin
          w_state_nx = LAP;
          w_lap_load = 1'b1;
        end
      end
      LAP: begin
        if (w_start_ev)    w_state_nx = PAUSE;
        else if (w_lap_ev) w_state_nx = RUN;
      end
      PAUSE: begin
        if (w_start_ev)   w_state_nx = RUN;
        else if (w_clear) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Edge-detect history loads the live input in reset so a level held
  // across reset is not seen as an event afterwards.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_tick_q  <= tick_in;
      r_start_q <= btn_start;
      r_lap_q   <= btn_lap;
      r_clear_q <= btn_clear;
      r_state   <= IDLE;
      r_lap     <= '0;
      r_roll    <= 1'b0;
    end else begin
      r_tick_q  <= tick_in;
      r_start_q <= btn_start;
      r_lap_q   <= btn_lap;
      r_clear_q <= btn_clear;
      r_state   <= w_state_nx;
      r_roll    <= w_carry[3];
      if (w_clear) begin
        r_lap <= '0;
      end else if (w_lap_load) begin
        r_lap <= w_live;
      end
    end
  end

  assign w_disp = (r_state == LAP) ? r_lap : w_live;

  assign digit0     = w_disp[0];
  assign digit1     = w_disp[1];
  assign digit2     = w_disp[2];
  assign digit3     = w_disp[3];
  assign running    = w_counting;
  assign lap_active = (r_state == LAP);
  assign rollover   = r_roll;

endmodule
